// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and constants for the FIFO burst reader.
//   rd_state_e : controller state (IDLE / READ / FLUSH)
//   BUF_DEPTH  : entries in the read-latency absorbing buffer
//   CRW        : width of buffer occupancy / credit values
//   ptr_inc    : modulo-BUF_DEPTH pointer increment
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

    localparam int BUF_DEPTH = 3;
    localparam int CRW       = 2;

    typedef logic [CRW-1:0] credit_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Bundles the FIFO read port and the downstream valid/ready stream.
//   ren     : FIFO read enable          (reader -> FIFO)
//   empty   : FIFO empty flag           (FIFO -> reader)
//   dataout : FIFO read data, 1 cycle after ren
//   m_valid : downstream data valid     (reader -> consumer)
//   m_data  : downstream data
//   m_ready : downstream ready          (consumer -> reader)
// master = the burst reader, slave = FIFO + consumer side.
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
    parameter int DW = 3
);
    logic          ren;
    logic          empty;
    logic [DW-1:0] dataout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        output ren,
        input  empty,
        input  dataout,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  ren,
        output empty,
        output dataout,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// 3-entry circular buffer holding words returned by the FIFO.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write din at the tail
//   pop      : drop the head word
//   occ      : current occupancy (0..3)
//   head     : word at the head (meaningful when occ != 0)
// Storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output credit_t       occ,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [BUF_DEPTH];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + credit_t'(1);
                2'b01:   occ <= occ - credit_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drains burst_len words from a FIFO read port and forwards them on a
// valid/ready stream at full throughput, absorbing the FIFO's one-cycle read
// latency in a 3-entry buffer.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : burst request pulse, sampled in IDLE only
//   burst_len : words to read, sampled with start
//   busy      : burst active (drops in the cycle done is high)
//   done      : one-cycle completion pulse
//   word_cnt  : words delivered in the current / last burst
//   bus       : FIFO read port + downstream stream (master modport)
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DW   = 3,
    parameter int LENW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LENW-1:0]     burst_len,
    output logic                busy,
    output logic                done,
    output logic [LENW-1:0]     word_cnt,
    fifo_burst_reader_if.master bus
);

    rd_state_e     state_q;
    rd_state_e     state_d;
    logic [LENW-1:0] remaining_q;
    logic          inflight_p1;
    logic          zero_done_q;
    credit_t       occ;
    logic [DW-1:0] head;
    logic [2:0]    credit_sum;
    logic          hs;
    logic          flush_done;
    logic          start_burst;
    logic          start_zero;

    // Words already buffered plus the one in flight must leave room for the
    // word a new ren would return; this is what prevents buffer overflow.
    assign credit_sum  = {1'b0, occ} + {2'b00, inflight_p1};
    assign hs          = bus.m_valid && bus.m_ready;
    assign flush_done  = (state_q == FLUSH) && (occ == '0) && !inflight_p1;
    assign start_burst = (state_q == IDLE) && start && (burst_len != '0);
    assign start_zero  = (state_q == IDLE) && start && (burst_len == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_burst)          state_d = READ;
            READ:    if (remaining_q == '0)    state_d = FLUSH;
            FLUSH:   if (flush_done)           state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // FSM outputs; ren depends only on registered state and empty, never on
    // m_ready, so the FIFO side has no combinational path from downstream.
    always_comb begin
        bus.ren     = (state_q == READ) && !bus.empty && (remaining_q != '0) &&
                      (credit_sum < 3'd3);
        busy        = (state_q != IDLE) && !flush_done;
        done        = flush_done || zero_done_q;
        bus.m_valid = (occ != '0);
        bus.m_data  = bus.m_valid ? head : '0;
    end

    // Stage p1: read issued last cycle, dataout valid now
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining_q <= '0;
            inflight_p1 <= 1'b0;
            zero_done_q <= 1'b0;
            word_cnt    <= '0;
        end else begin
            inflight_p1 <= bus.ren;
            zero_done_q <= start_zero;
            if (start_burst)  remaining_q <= burst_len;
            else if (bus.ren) remaining_q <= remaining_q - LENW'(1);
            if ((state_q == IDLE) && start) word_cnt <= '0;
            else if (hs)                    word_cnt <= word_cnt + LENW'(1);
        end
    end

    // Stage p2: word captured in the buffer, presented downstream
    rd_skid_buf #(.DW(DW)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_p1),
        .din  (bus.dataout),
        .pop  (hs),
        .occ  (occ),
        .head (head)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DW   = 3;
    localparam int LENW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LENW-1:0] burst_len;
    logic            busy;
    logic            done;
    logic [LENW-1:0] word_cnt;

    fifo_burst_reader_if #(.DW(DW)) bus ();

    fifo_burst_reader #(.DW(DW), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: one-cycle read latency
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (bus.ren) begin
            if (fifo_q.size() != 0) bus.dataout <= fifo_q.pop_front();
            else                    bus.dataout <= '0;
        end
    end

    // Monitor, sampled on the falling edge
    logic          mon_clr = 1'b0;
    int            ren_cnt, first_ren, last_ren;
    int            valid_cnt, first_valid, last_valid;
    int            done_cnt, done_cyc, last_hs;
    int            ren_empty_err, stab_err, busy_cnt;
    logic          prev_valid, prev_ready;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] rx_q[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            ren_cnt <= 0; first_ren <= 0; last_ren <= 0;
            valid_cnt <= 0; first_valid <= 0; last_valid <= 0;
            done_cnt <= 0; done_cyc <= 0; last_hs <= 0;
            ren_empty_err <= 0; stab_err <= 0; busy_cnt <= 0;
            prev_valid <= 1'b0; prev_ready <= 1'b0; prev_data <= '0;
            rx_q.delete();
        end else if (rst) begin
            if (bus.ren) begin
                if (ren_cnt == 0) first_ren <= cyc;
                last_ren <= cyc;
                ren_cnt  <= ren_cnt + 1;
                if (bus.empty) ren_empty_err <= ren_empty_err + 1;
            end
            if (bus.m_valid) begin
                if (valid_cnt == 0) first_valid <= cyc;
                last_valid <= cyc;
                valid_cnt  <= valid_cnt + 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                rx_q.push_back(bus.m_data);
                last_hs <= cyc;
            end
            if (prev_valid && !prev_ready && (!bus.m_valid || bus.m_data != prev_data))
                stab_err <= stab_err + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            prev_valid <= bus.m_valid;
            prev_ready <= bus.m_ready;
            prev_data  <= bus.m_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic load_word(input int w);
        fifo_q.push_back(w[DW-1:0]);
        exp_q.push_back(w[DW-1:0]);
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1 start = 1'b1;
        burst_len = len[LENW-1:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && done_cnt == 0; i++) @(posedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check_eq($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        burst_len   = '0;
        bus.empty   = 1'b1;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",    busy,        0);
        check_eq("rst_done",    done,        0);
        check_eq("rst_ren",     bus.ren,     0);
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_m_data",  bus.m_data,  0);
        check_eq("rst_word_cnt", word_cnt,   0);
        rst = 1'b1;
        clear_mon();

        // 1: full throughput
        bus.empty = 1'b0; bus.m_ready = 1'b1;
        load_word(5); load_word(2); load_word(7); load_word(1);
        pulse_start(4);
        wait_done(50);
        check_eq("t1_ren_cnt",      ren_cnt, 4);
        check_eq("t1_ren_span",     last_ren - first_ren, 3);
        check_eq("t1_valid_lat",    first_valid - first_ren, 2);
        check_eq("t1_valid_cnt",    valid_cnt, 4);
        check_eq("t1_valid_span",   last_valid - first_valid, 3);
        check_eq("t1_done_cnt",     done_cnt, 1);
        check_eq("t1_done_after_hs", done_cyc - last_hs, 1);
        check_eq("t1_word_cnt",     word_cnt, 4);
        check_rx("t1");
        clear_mon();

        // 2: backpressure
        bus.m_ready = 1'b0;
        load_word(3); load_word(6); load_word(1); load_word(4);
        load_word(0); load_word(7); load_word(2); load_word(5);
        pulse_start(8);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t2_ren_cnt_stall", ren_cnt, 3);
        check_eq("t2_m_valid",       bus.m_valid, 1);
        check_eq("t2_m_data_head",   bus.m_data, 3);
        check_eq("t2_busy",          busy, 1);
        bus.m_ready = 1'b1;
        wait_done(80);
        check_eq("t2_stable",   stab_err, 0);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_word_cnt", word_cnt, 8);
        check_rx("t2");
        clear_mon();

        // 3: empty toggling every 2 cycles
        bus.empty = 1'b1;
        load_word(6); load_word(5); load_word(4); load_word(3); load_word(2); load_word(1);
        pulse_start(6);
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            bus.empty = ((i / 2) % 2 == 0);
            @(posedge clk);
            #1;
        end
        bus.empty = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t3_ren_while_empty", ren_empty_err, 0);
        check_eq("t3_ren_cnt",  ren_cnt, 6);
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_word_cnt", word_cnt, 6);
        check_rx("t3");
        clear_mon();

        // 4: zero-length burst, then maximum burst
        @(posedge clk);
        #1 start = 1'b1; burst_len = '0;
        @(posedge clk);
        #1;
        check_eq("t4_zero_done", done, 1);
        check_eq("t4_zero_busy", busy, 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t4_zero_done_once", done, 0);
        repeat (3) @(posedge clk);
        check_eq("t4_zero_ren",      ren_cnt, 0);
        check_eq("t4_zero_valid",    valid_cnt, 0);
        check_eq("t4_zero_busy_cnt", busy_cnt, 0);
        check_eq("t4_zero_done_cnt", done_cnt, 1);
        check_eq("t4_zero_word_cnt", word_cnt, 0);
        clear_mon();
        for (int i = 1; i <= 15; i++) load_word(i % 8);
        pulse_start(15);
        wait_done(100);
        check_eq("t4_max_ren_cnt",  ren_cnt, 15);
        check_eq("t4_max_done_cnt", done_cnt, 1);
        check_eq("t4_max_word_cnt", word_cnt, 15);
        check_rx("t4_max");
        clear_mon();

        // 5: start ignored mid-burst, then reset mid-burst
        load_word(4); load_word(1); load_word(6); load_word(3); load_word(0);
        pulse_start(5);
        @(posedge clk);
        #1 start = 1'b1; burst_len = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(60);
        repeat (6) @(posedge clk);
        check_eq("t5_ren_cnt",  ren_cnt, 5);
        check_eq("t5_done_cnt", done_cnt, 1);
        check_eq("t5_word_cnt", word_cnt, 5);
        check_rx("t5");
        clear_mon();

        load_word(1); load_word(2); load_word(3); load_word(4); load_word(5); load_word(6);
        pulse_start(6);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_rst_busy",    busy, 0);
        check_eq("t5_rst_ren",     bus.ren, 0);
        check_eq("t5_rst_m_valid", bus.m_valid, 0);
        check_eq("t5_rst_word_cnt", word_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        clear_mon();
        load_word(7); load_word(3); load_word(5);
        pulse_start(3);
        wait_done(50);
        repeat (4) @(posedge clk);
        check_eq("t5_post_ren_cnt",  ren_cnt, 3);
        check_eq("t5_post_done_cnt", done_cnt, 1);
        check_eq("t5_post_word_cnt", word_cnt, 3);
        check_rx("t5_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
